// File: rtl/mmio_store_sink.sv
// End-of-test responder on the core store port: logs stores into a drainable FIFO,
// decodes the TOHOST mailbox / error PC / cycle budget into a sticky registered verdict.
module mmio_store_sink #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0064,
    parameter logic [31:0] PASS_VALUE     = 32'd25,
    parameter logic [31:0] ERROR_PC       = 32'h0000_004C,
    parameter int unsigned TIMEOUT_CYCLES = 70,
    parameter int unsigned LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        MemWrite,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        overflow,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count
);

    localparam int unsigned PW = $clog2(LOG_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] OCC_FULL = CW'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          timeout_q, timeout_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   store_count_q, store_count_d;
    logic [31:0]   cycle_count_q, cycle_count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [31:0]   mem_addr_q [LOG_DEPTH];
    logic [31:0]   mem_data_q [LOG_DEPTH];

    logic head_valid;
    logic push;
    logic pop;
    logic full;
    logic wr_en;

    // Verdict next-state: error PC beats the mailbox, the mailbox beats the timeout.
    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        case (state_q)
            ST_RUN: begin
                cycle_count_d = cycle_count_q + 32'd1;
                if (PC == ERROR_PC) begin
                    state_d = ST_FAIL;
                end else if (MemWrite && (DataAddress == TOHOST_ADDR)) begin
                    if (WriteData == PASS_VALUE) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (cycle_count_q == TIMEOUT_LAST) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        done_d    = (state_d != ST_RUN);
        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    // Store-log FIFO control; a full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        head_valid = (occ_q != {CW{1'b0}});
        push       = MemWrite && (state_q == ST_RUN);
        pop        = head_valid && log_ready;
        full       = (occ_q == OCC_FULL);
        wr_en      = push && (!full || pop);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        overflow_d = overflow_q || (push && full && !pop);

        if (push && (store_count_q != 16'hFFFF)) begin
            store_count_d = store_count_q + 16'd1;
        end else begin
            store_count_d = store_count_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            store_count_q <= 16'd0;
            cycle_count_q <= 32'd0;
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            occ_q         <= {CW{1'b0}};
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            overflow_q    <= overflow_d;
            store_count_q <= store_count_d;
            cycle_count_q <= cycle_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // Log storage; contents are don't-care until validated by the occupancy count.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_addr_q[wr_ptr_q] <= DataAddress;
            mem_data_q[wr_ptr_q] <= WriteData;
        end
    end

    assign log_valid   = head_valid;
    assign log_addr    = head_valid ? mem_addr_q[rd_ptr_q] : 32'h0000_0000;
    assign log_data    = head_valid ? mem_data_q[rd_ptr_q] : 32'h0000_0000;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign store_count = store_count_q;
    assign cycle_count = cycle_count_q;

endmodule
